// File: rtl/rv_ifetch_buf.sv
// rv_ifetch_buf: instruction fetch unit with a 2-entry prefetch FIFO.
// Owns the fetch PC, drives the ROM word address, and captures
// {pc, instr} pairs into a small FIFO. Decode reads the head entry
// through a valid/ready handshake. A redirect from execute flushes the
// FIFO and restarts fetch at the (word-aligned) target.
module rv_ifetch_buf #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ROM_DEPTH  = 1024,
    parameter int unsigned           AW         = $clog2(ROM_DEPTH),
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [AW-1:0]         instr_addr_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o
);

    localparam int unsigned DEPTH = 2;

    // Sequential PC step; wraps modulo 2^DATA_WIDTH by truncation.
    function automatic logic [DATA_WIDTH-1:0] pc_plus4(input logic [DATA_WIDTH-1:0] pc);
        return pc + DATA_WIDTH'(4);
    endfunction

    // Redirect targets are byte addresses; the two low bits are dropped.
    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] pc);
        return pc & ~DATA_WIDTH'(3);
    endfunction

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  full;
    logic                  pop;
    logic                  push;

    // ---- fetch stage: ROM address and handshake control ----

    // The ROM address follows fetch_pc directly; when the FIFO is full
    // the PC simply holds and the same word is re-read next cycle.
    assign instr_addr_o = fetch_pc[AW+1:2];

    assign full    = (count == 2'd2);
    assign valid_o = (count != 2'd0);
    assign pop     = valid_o & ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO can still
    // accept when decode is draining it. Redirect suppresses the push.
    assign push    = ~redirect_i & (~full | pop);

    // Fetch PC: redirect wins, otherwise advance on every accepted push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= word_align(redirect_pc_i);
        end else if (push) begin
            fetch_pc <= pc_plus4(fetch_pc);
        end
    end

    // FIFO pointers and occupancy; a redirect discards every entry,
    // including one handed to decode in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // ---- buffer stage: registered {pc, instr} storage ----

    // Capture the ROM word together with the PC that addressed it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= instr_i;
        end
    end

    // ---- decode interface: head slot, no path from instr_i ----

    assign instr_o = instr_mem[rd_ptr];
    assign pc_o    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_rv_ifetch_buf.sv
// Testbench for rv_ifetch_buf: streaming, backpressure, redirect,
// redirect with concurrent handshake, async reset, and PC wrap.
module tb_rv_ifetch_buf;

    logic        clk;
    logic        rstn;
    logic [9:0]  instr_addr;
    logic [31:0] instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    logic        rstn_w;
    logic [9:0]  instr_addr_w;
    logic [31:0] instr_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic        valid_w;
    logic        ready_w;
    logic [31:0] instr_o_w;
    logic [31:0] pc_o_w;

    int n_cmp;
    int n_bad;

    logic [63:0] exp_q [$];
    logic [63:0] exp_w [$];

    // ROM model: ROM[k] = 32'h1000_0000 + k
    assign instr   = 32'h1000_0000 + 32'(instr_addr);
    assign instr_w = 32'h1000_0000 + 32'(instr_addr_w);

    rv_ifetch_buf #(
        .DATA_WIDTH(32), .ROM_DEPTH(1024), .AW(10), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rstn(rstn), .instr_addr_o(instr_addr), .instr_i(instr),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .valid_o(valid),
        .ready_i(ready), .instr_o(instr_o), .pc_o(pc_o)
    );

    rv_ifetch_buf #(
        .DATA_WIDTH(32), .ROM_DEPTH(1024), .AW(10), .RESET_PC(32'hFFFF_FFFC)
    ) dut_w (
        .clk(clk), .rstn(rstn_w), .instr_addr_o(instr_addr_w), .instr_i(instr_w),
        .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w), .valid_o(valid_w),
        .ready_i(ready_w), .instr_o(instr_o_w), .pc_o(pc_o_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake of either DUT.
    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (valid && ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL main unexpected delivery: got pc=%h instr=%h, required none",
                             pc_o, instr_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({pc_o, instr_o} !== e) begin
                        n_bad++;
                        $display("FAIL main delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                                 pc_o, instr_o, e[63:32], e[31:0]);
                    end
                end
            end
            if (valid_w && ready_w) begin
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap unexpected delivery: got pc=%h instr=%h, required none",
                             pc_o_w, instr_o_w);
                end else begin
                    e = exp_w.pop_front();
                    if ({pc_o_w, instr_o_w} !== e) begin
                        n_bad++;
                        $display("FAIL wrap delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                                 pc_o_w, instr_o_w, e[63:32], e[31:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rstn_w = 1'b0; ready_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) step();
        check("rst valid", 64'(valid), 64'd0);
        check("rst pc", 64'(pc_o), 64'd0);
        check("rst instr", 64'(instr_o), 64'd0);
        check("rst addr", 64'(instr_addr), 64'd0);

        // Stream with ready held high: 8 deliveries
        ready = 1'b1;
        for (int k = 0; k < 8; k++)
            exp_q.push_back({32'(4 * k), 32'h1000_0000 + 32'(k)});
        rstn = 1'b1;
        repeat (9) step();
        ready = 1'b0;
        check("stream drained", 64'(exp_q.size()), 64'd0);

        // Backpressure from a fresh reset
        rstn = 1'b0;
        repeat (2) step();
        check("rst2 valid", 64'(valid), 64'd0);
        rstn = 1'b1;
        repeat (5) step();
        check("bp valid", 64'(valid), 64'd1);
        check("bp head pc", 64'(pc_o), 64'd0);
        check("bp head instr", 64'(instr_o), 64'h1000_0000);
        check("bp addr stuck", 64'(instr_addr), 64'd2);
        exp_q.push_back({32'h0, 32'h1000_0000});
        exp_q.push_back({32'h4, 32'h1000_0001});
        exp_q.push_back({32'h8, 32'h1000_0002});
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        check("bp drained", 64'(exp_q.size()), 64'd0);
        check("bp next head", 64'(pc_o), 64'h0C);
        check("bp addr", 64'(instr_addr), 64'd5);

        // Redirect while full, unaligned target
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        step();
        redirect = 1'b0;
        check("redir valid low", 64'(valid), 64'd0);
        check("redir addr", 64'(instr_addr), 64'h10);
        exp_q.push_back({32'h40, 32'h1000_0010});
        ready = 1'b1;
        repeat (2) step();
        ready = 1'b0;
        check("redir drained", 64'(exp_q.size()), 64'd0);

        // Redirect with concurrent handshake
        step();
        check("hs head pc", 64'(pc_o), 64'h44);
        exp_q.push_back({32'h44, 32'h1000_0011});
        exp_q.push_back({32'h100, 32'h1000_0040});
        exp_q.push_back({32'h104, 32'h1000_0041});
        ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        check("hs redir valid low", 64'(valid), 64'd0);
        repeat (3) step();
        ready = 1'b0;
        check("hs drained", 64'(exp_q.size()), 64'd0);

        // Async reset between edges with the FIFO full
        repeat (2) step();
        check("pre-async valid", 64'(valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async valid", 64'(valid), 64'd0);
        check("async pc", 64'(pc_o), 64'd0);
        check("async instr", 64'(instr_o), 64'd0);
        check("async addr", 64'(instr_addr), 64'd0);
        step();
        exp_q.push_back({32'h0, 32'h1000_0000});
        exp_q.push_back({32'h4, 32'h1000_0001});
        exp_q.push_back({32'h8, 32'h1000_0002});
        ready = 1'b1;
        rstn = 1'b1;
        repeat (4) step();
        ready = 1'b0;
        check("async restart drained", 64'(exp_q.size()), 64'd0);

        // PC and ROM address wrap
        check("wrap rst valid", 64'(valid_w), 64'd0);
        check("wrap rst addr", 64'(instr_addr_w), 64'h3FF);
        exp_w.push_back({32'hFFFF_FFFC, 32'h1000_03FF});
        exp_w.push_back({32'h0000_0000, 32'h1000_0000});
        exp_w.push_back({32'h0000_0004, 32'h1000_0001});
        ready_w = 1'b1;
        rstn_w = 1'b1;
        step();
        check("wrap addr", 64'(instr_addr_w), 64'd0);
        repeat (3) step();
        ready_w = 1'b0;
        check("wrap drained", 64'(exp_w.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_ifetch_buf.md
# rv_ifetch_buf

Instruction fetch unit and 2-entry prefetch buffer between the instruction ROM and the decode stage of `rv_core`. It owns the fetch PC and drives the ROM word address. It captures the ROM's combinational read data together with its PC into a small FIFO, and presents instructions to decode through a valid/ready handshake. Branch/jump redirects from the execute stage flush the buffer and restart fetch at the target.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction and PC width (`DATA_WIDTH` define).
- `ROM_DEPTH`, 1024: ROM depth in words (`ROM_DEPTH` define).
- `AW`, `$clog2(ROM_DEPTH)`: ROM word-address width.
- `RESET_PC`, 32'h0000_0000: first fetch address (byte address).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `instr_addr_o`  out  AW  ROM word address, equal to `fetch_pc[AW+1:2]`.
- `instr_i`  in  DATA_WIDTH  ROM read data (combinational from `instr_addr_o`).
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_pc_i`  in  DATA_WIDTH  redirect target (byte address).
- `valid_o`  out  1  head entry available to decode.
- `ready_i`  in  1  decode accepts head entry.
- `instr_o`  out  DATA_WIDTH  head instruction.
- `pc_o`  out  DATA_WIDTH  PC of head instruction.

## Operation
- State: `fetch_pc` (DATA_WIDTH), 2-entry FIFO of {pc, instr}, write pointer, read pointer and count (0..2).
- `pop` = `valid_o & ready_i`.
- `push` = `~redirect_i & (count < 2 | pop)`. Push writes {`fetch_pc`, `instr_i`} and advances `fetch_pc` by 4.
- Pop advances the read pointer. Simultaneous push and pop leaves `count` unchanged, including when `count` = 2.
- Redirect has priority over push and pop.
  - Redirect clears `count` and both pointers.
  - Redirect loads `fetch_pc` with `{redirect_pc_i[31:2], 2'b00}`. Bits [1:0] are ignored.
  - A handshake asserted in the same cycle as a redirect counts as completed by decode. The entry is discarded with the rest of the FIFO.
- `valid_o` = `count != 0`. `instr_o`/`pc_o` come from the head FIFO slot, registered storage only; there is no combinational path from `instr_i`.
- The ROM address is never stalled combinationally. When the FIFO is full and there is no pop, `fetch_pc` holds and the ROM is re-read next cycle.
- Arithmetic: `fetch_pc + 4` wraps modulo 2^DATA_WIDTH. `instr_addr_o` wraps modulo ROM_DEPTH by truncation; no out-of-range detection.
- Reset is asynchronous assert and synchronous-edge release. It may arrive at any time, including mid-redirect or with the FIFO full; all state returns to reset values immediately.

## Timing
- Reset values: `fetch_pc` = RESET_PC, `instr_addr_o` = RESET_PC[AW+1:2], `count` = 0, `valid_o` = 0. `instr_o` and `pc_o` = 0 (storage cleared).
- First edge after `rstn` rises: entry RESET_PC pushed. `valid_o` = 1 from that edge.
- Fetch-to-valid latency: 1 cycle.
- Redirect latency: redirect sampled at edge N gives `valid_o` = 0 during cycle N→N+1. The target instruction is valid after edge N+1.
- Steady state with `ready_i` held high: one instruction per cycle, consecutive PCs, no bubbles.
- With `ready_i` low: the FIFO fills after 2 edges. `valid_o`, `instr_o` and `pc_o` then hold stable until pop.

## Test plan
- Reset and stream: ROM[k] = 32'h1000_0000+k, RESET_PC = 0, `ready_i` = 1. Expect `valid_o` = 0 during reset, then `pc_o` = 0,4,8,… and `instr_o` = 32'h1000_0000,…01,…02, one per cycle.
- Backpressure: `ready_i` = 0 for 5 cycles after reset. Expect `count` = 2, head held at pc 0, `instr_addr_o` stuck at word 2. After releasing, expect pcs 0,4,8 in order with no loss or duplication.
- Redirect: `redirect_i` = 1 with `redirect_pc_i` = 32'h0000_0043 while the FIFO is full. Expect `valid_o` = 0 the next cycle, then `pc_o` = 32'h40 and `instr_o` = ROM[16].
- Redirect with concurrent handshake: `valid_o` = `ready_i` = `redirect_i` = 1 in one cycle. Expect no stale entry delivered afterwards; the next delivered pc is the target.
- Wrap: RESET_PC = 32'hFFFF_FFFC. Expect pcs FFFF_FFFC then 0000_0000, with `instr_addr_o` wrapping to ROM_DEPTH-1 then 0.
- Async reset mid-stream: drop `rstn` between clock edges with `count` = 2. Expect `valid_o` = 0 immediately (before the next edge) and fetch restarting at RESET_PC after release.
